// File: rtl/mem_bus_controller.sv
// mem_bus_controller: load/store sequencer serving a 17 x 16-bit register
// bank and forwarding other accesses to a fixed-latency synchronous RAM.
module mem_bus_controller #(
    parameter int RAM_LAT = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ,
    input  logic          WE,
    input  logic [15:0]   ADD,
    input  logic [15:0]   WDATA,
    input  logic [16:0]   SEL,
    input  logic          RAM_S,
    output logic [15:0]   RDATA,
    output logic          ACK,
    output logic          ERR,
    output logic          BUSY,
    output logic [271:0]  REGS,
    output logic          RAM_EN,
    output logic          RAM_WE,
    output logic [15:0]   RAM_ADD,
    output logic [15:0]   RAM_WDATA,
    input  logic [15:0]   RAM_RDATA
);

    typedef enum logic [2:0] {
        IDLE,
        REG,
        RAM_REQ,
        RAM_WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        we_q;
    logic [15:0] wdata_q;
    logic [16:0] sel_q;
    logic [2:0]  cnt;
    logic [15:0] bank [17];

    logic        sel_one;
    logic [4:0]  sel_idx;

    for (genvar k = 0; k < 17; k++) begin : g_regs
        assign REGS[16*k +: 16] = bank[k];
    end

    // Decode the latched select: exactly-one-hot test and the hot bit index.
    always_comb begin
        sel_one = (sel_q != '0) && ((sel_q & (sel_q - 17'd1)) == '0);
        sel_idx = '0;
        for (int i = 0; i < 17; i++) begin
            if (sel_q[i]) sel_idx = 5'(i);
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; a RAM read waits out the latency counter.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (REQ) state_next = RAM_S ? RAM_REQ : REG;
            REG:      state_next = RESP;
            RAM_REQ:  state_next = we_q ? RESP : RAM_WAIT;
            RAM_WAIT: if (cnt == '0) state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; status flags follow the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q      <= 1'b0;
            wdata_q   <= '0;
            sel_q     <= '0;
            cnt       <= '0;
            RDATA     <= '0;
            ACK       <= 1'b0;
            ERR       <= 1'b0;
            BUSY      <= 1'b0;
            RAM_EN    <= 1'b0;
            RAM_WE    <= 1'b0;
            RAM_ADD   <= '0;
            RAM_WDATA <= '0;
            for (int k = 0; k < 17; k++) bank[k] <= '0;
        end else begin
            ACK    <= (state_next == RESP);
            ERR    <= (state == REG) && !sel_one;
            BUSY   <= (state_next != IDLE);
            RAM_EN <= (state_next == RAM_REQ);
            RAM_WE <= (state_next == RAM_REQ) && WE;
            unique case (state)
                IDLE: begin
                    if (REQ) begin
                        we_q    <= WE;
                        wdata_q <= WDATA;
                        sel_q   <= SEL;
                        if (RAM_S) begin
                            RAM_ADD   <= ADD;
                            RAM_WDATA <= WDATA;
                        end
                    end
                end
                REG: begin
                    if (!sel_one)  RDATA <= '0;
                    else if (we_q) bank[sel_idx] <= wdata_q;
                    else           RDATA <= bank[sel_idx];
                end
                RAM_REQ: begin
                    if (!we_q) cnt <= 3'(RAM_LAT - 1);
                end
                RAM_WAIT: begin
                    if (cnt == '0) RDATA <= RAM_RDATA;
                    else           cnt <= cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_controller.md
# mem_bus_controller

Sequential memory-access controller that sits directly downstream of the address selector. It consumes the selector's 17-bit one-hot register select and RAM select for each CPU load/store. Register hits (addresses 0x0000–0x0010) are served from an internal bank of 17 × 16-bit memory-mapped registers. RAM hits (address ≥ 0x0011) are forwarded to a synchronous RAM with fixed read latency. Every access returns a one-cycle ACK with read data.

## Interface
Parameters:
- RAM_LAT, 2, cycles from RAM_EN sample to valid RAM_RDATA; legal range 1–7.

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- REQ  in  1  access request, sampled only in IDLE
- WE  in  1  1 = write, 0 = read
- ADD  in  16  access address (also drives the address selector)
- WDATA  in  16  write data
- SEL  in  17  one-hot register select from the address selector
- RAM_S  in  1  RAM select from the address selector (1 = RAM access)
- RDATA  out  16  read data, valid while ACK=1, held until next ACK
- ACK  out  1  one-cycle completion pulse
- ERR  out  1  asserted with ACK when the register select is invalid
- BUSY  out  1  high in every non-IDLE state
- REGS  out  272  register bank, flat; reg k = REGS[16k+15:16k]
- RAM_EN  out  1  RAM access strobe, one cycle
- RAM_WE  out  1  RAM write enable, qualified by RAM_EN
- RAM_ADD  out  16  RAM address
- RAM_WDATA  out  16  RAM write data
- RAM_RDATA  in  16  RAM read data

## Operation
- States: IDLE, REG, RAM_REQ, RAM_WAIT, RESP.
- IDLE, REQ=1: latch ADD, WE, WDATA, SEL and RAM_S.
  - If RAM_S=1, go to RAM_REQ.
  - Otherwise go to REG.
- IDLE, REQ=0: stay in IDLE.
- REG:
  - Valid select = SEL has exactly one bit set (index k). A write loads reg k with WDATA; a read captures reg k into RDATA.
  - Invalid select = SEL is zero or has more than one bit set. Set the error flag, set RDATA=0 and change no register.
  - Go to RESP.
- RAM_REQ:
  - RAM_EN=1, RAM_WE=latched WE, RAM_ADD=latched ADD, RAM_WDATA=latched WDATA, for exactly one cycle.
  - A write goes to RESP. A read goes to RAM_WAIT and loads the latency counter with RAM_LAT−1.
- RAM_WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 0, capture RAM_RDATA into RDATA and go to RESP.
- RESP: ACK=1 and ERR=flag for one cycle, then go to IDLE and clear the flag.
- REQ outside IDLE (including RESP) is ignored. The requester holds REQ until it sees ACK.
- Minimum request-to-request spacing: 3 cycles for register accesses, 3 cycles for RAM writes, 3+RAM_LAT cycles for RAM reads.
- SEL and RAM_S are taken only from the selector. Address decoding is not duplicated in this block.

## Timing
- REQ sampled at edge t.
- Register access: write takes effect at edge t+1; ACK is high during cycle t+2.
- RAM access: RAM_EN is high during cycle t+1.
  - Write: ACK during cycle t+2.
  - Read: RAM_RDATA is sampled at edge t+1+RAM_LAT; ACK during cycle t+2+RAM_LAT.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: state=IDLE; ACK, ERR, BUSY, RAM_EN, RAM_WE = 0; RDATA, RAM_ADD, RAM_WDATA = 0; all 17 registers = 0x0000; counter = 0.
- Reset mid-operation, from any state: return to IDLE on the next edge.
  - No ACK is issued for the aborted access and RAM_EN drops.
  - Any register write already committed is then cleared by the reset.
- REQ=1 in the first cycle after RST deasserts is accepted normally.
- Register write and RDATA update never occur in the same cycle as reset.

## Test plan
- Reset: hold RST 2 cycles with REQ=1 -> ACK, BUSY, RAM_EN, RDATA and REGS all 0; no access starts.
- Register write then read: ADD=0x0005, SEL=bit5, RAM_S=0, WE=1, WDATA=0xBEEF at t -> ACK at t+2, REGS[95:80]=0xBEEF, RAM_EN never high. Read of 0x0005 -> RDATA=0xBEEF with ACK. Same write/read check at 0x0010 (bit16).
- RAM write: ADD=0x0011, RAM_S=1, WE=1, WDATA=0x1234 -> RAM_EN=RAM_WE=1 with RAM_ADD=0x0011 and RAM_WDATA=0x1234 in cycle t+1 only; ACK at t+2.
- RAM read, RAM_LAT=2, model returns 0xCAFE for 0x0100 -> RAM_EN at t+1, ACK at t+4 with RDATA=0xCAFE.
  - Repeat with RAM_LAT=1 -> ACK at t+3.
  - Repeat with RAM_LAT=7 -> ACK at t+9.
- Invalid select: RAM_S=0, SEL=0x00000, WE=1 -> ACK=ERR=1 at t+2, RDATA=0, REGS unchanged.
  - Repeat with SEL=0x00003 -> same response.
  - Following valid access -> ERR=0.
- Busy/abort: hold REQ=1 continuously -> new accesses accepted only in IDLE, at the 3-cycle spacing.
  - Assert RST during RAM_WAIT -> no ACK, BUSY=0 next cycle.
  - A REQ right after reset completes normally.
